fpu_add_align: RTL and testbench
================================

FPU_ADD_ALIGN -- requirements
Module: fpu_add_align

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1: operand pair valid.
REQ-004 SHALL have port in_ready, output, 1: block accepts a pair this cycle.
REQ-005 SHALL have port add_sub, input, 1: 1 = opa+opb, 0 = opa-opb.
REQ-006 SHALL have ports opa and opb, input, 32 each: IEEE-754 single-precision operands.
REQ-007 SHALL have port out_valid, output, 1: aligned result valid.
REQ-008 SHALL have port out_ready, input, 1: downstream adder/normalizer accepts.
REQ-009 SHALL have port out_exp, output, 8: exponent of larger-magnitude operand; a denormal exponent reads as 1.
REQ-010 SHALL have ports out_mant_a and out_mant_b, output, 27 each: [26] hidden bit, [25:3] fraction, [2:0] guard/round/sticky.
REQ-011 SHALL have port out_sign, output, 1: sign of larger operand; effective sign when that operand is opb.
REQ-012 SHALL have ports out_eff_sub, out_swapped, out_nan, out_inf, output, 1 each.

Function
REQ-013 Transfer SHALL occur on in_valid&in_ready at input and on out_valid&out_ready at output.
REQ-014 Pipeline SHALL be 2 register stages: S1 unpack/compare/swap, S2 shift/sticky; latency is 2 cycles from accept to out_valid with out_ready held high.
REQ-015 Throughput SHALL be 1 pair/cycle when out_ready=1.
REQ-016 A stage SHALL load when it is empty or its contents move on the same cycle; it SHALL hold otherwise.
REQ-017 in_ready SHALL equal !(S1 valid && S2 valid && !out_ready); it is combinational from out_ready.
REQ-018 Output data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 Effective opb sign SHALL be opb[31]^~add_sub, and eff_sub SHALL be opa[31]^(effective opb sign).
REQ-020 Swap SHALL occur iff opb[30:0] > opa[30:0] (unsigned); a tie SHALL not swap; out_swapped SHALL be 1 iff swapped.
REQ-021 Unpack: exp=0 SHALL give hidden=0 and effective exp=1; otherwise hidden=1.
REQ-022 Shift: diff = larger exp - smaller exp (0..254); the smaller mantissa SHALL shift right by diff.
REQ-023 Bits shifted past bit 0 SHALL be OR-ed into bit 0 (sticky).
REQ-024 When diff >= 27, out_mant_b SHALL be 27'h1 if the smaller mantissa is nonzero and 0 otherwise.
REQ-025 out_mant_a SHALL be the larger mantissa, unshifted, with [2:0]=0.
REQ-026 out_nan SHALL be 1 if either operand has exp=255 with frac!=0, or both are infinite with eff_sub=1.
REQ-027 out_inf SHALL be 1 if either operand is infinite and out_nan=0; out_sign then gives the infinity sign.
REQ-028 Mantissa/exp outputs SHALL still be computed normally when out_nan or out_inf is set; downstream ignores them.
REQ-029 Exact cancellation (equal magnitudes, eff_sub=1) SHALL be passed unchanged; zero-sign resolution is downstream.

Reset
REQ-030 While rst_n=0 (asynchronously): S1/S2 valid=0, out_valid=0, all data registers 0, in_ready=1 after release.
REQ-031 Reset mid-operation SHALL discard all in-flight pairs; no output SHALL follow reset release until new pairs are accepted.

Verification
REQ-032 opa=opb=0x3F800000, add_sub=1, out_ready=1 -> 2 cycles later out_valid=1, out_exp=0x7F, mant_a=mant_b=0x4000000, eff_sub=0, swapped=0.
REQ-033 opa=0x3F800000, opb=0x4B800000, add_sub=1 -> swapped=1, out_exp=0x97, mant_a=0x4000000, mant_b=0x0000004.
REQ-034 opa=0x3F800000, opb=0x4D800000, add_sub=0 -> swapped=1, out_exp=0x9B, mant_b=0x0000001 (sticky only), eff_sub=1, out_sign=1.
REQ-035 opa=opb=0x7F800000, add_sub=0 -> out_nan=1, out_inf=0; opa=0x7F800000, opb=0x3F800000, add_sub=1 -> out_inf=1, out_sign=0.
REQ-036 out_ready=0 for 6 cycles while 4 pairs are offered back-to-back -> exactly 2 accepted, in_ready=0 from the 3rd offer, out_data stable; after out_ready=1 all 4 emerge in order with no loss or duplicate.
REQ-037 rst_n pulsed low for 1 cycle with 2 pairs in flight -> out_valid drops immediately, in_ready=1 after release, and neither pair appears at the output.

Source files
------------

// File: rtl/fpu_add_align.sv
// Two-stage alignment front end for a single-precision adder: S1 unpacks, compares
// and swaps the operands, S2 right-shifts the smaller mantissa with sticky collection.
module fpu_add_align (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        add_sub,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_exp,
  output logic [26:0] out_mant_a,
  output logic [26:0] out_mant_b,
  output logic        out_sign,
  output logic        out_eff_sub,
  output logic        out_swapped,
  output logic        out_nan,
  output logic        out_inf
);

  logic        s1_valid_q, s2_valid_q;
  logic        s1_load, s2_load;

  logic [7:0]  s1_exp_l_q, s1_exp_s_q, s1_exp_l_d, s1_exp_s_d;
  logic [23:0] s1_mant_l_q, s1_mant_s_q, s1_mant_l_d, s1_mant_s_d;
  logic        s1_sign_q, s1_eff_sub_q, s1_swapped_q, s1_nan_q, s1_inf_q;
  logic        s1_sign_d, s1_eff_sub_d, s1_swapped_d, s1_nan_d, s1_inf_d;

  logic [7:0]  out_exp_q;
  logic [26:0] out_mant_a_q, out_mant_b_q, out_mant_b_d;
  logic        out_sign_q, out_eff_sub_q, out_swapped_q, out_nan_q, out_inf_q;

  // A stage accepts new data when empty or when its contents leave this cycle.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  logic        b_sign_eff;
  logic        a_exp_zero, b_exp_zero;
  logic [7:0]  a_exp, b_exp;
  logic [23:0] a_mant, b_mant;
  logic        a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    b_sign_eff   = opb[31] ^ ~add_sub;
    a_exp_zero   = (opa[30:23] == 8'd0);
    b_exp_zero   = (opb[30:23] == 8'd0);
    a_exp        = a_exp_zero ? 8'd1 : opa[30:23];
    b_exp        = b_exp_zero ? 8'd1 : opb[30:23];
    a_mant       = {~a_exp_zero, opa[22:0]};
    b_mant       = {~b_exp_zero, opb[22:0]};
    a_nan        = (&opa[30:23]) && (|opa[22:0]);
    b_nan        = (&opb[30:23]) && (|opb[22:0]);
    a_inf        = (&opa[30:23]) && !(|opa[22:0]);
    b_inf        = (&opb[30:23]) && !(|opb[22:0]);

    s1_eff_sub_d = opa[31] ^ b_sign_eff;
    s1_swapped_d = (opb[30:0] > opa[30:0]);
    s1_nan_d     = a_nan || b_nan || (a_inf && b_inf && s1_eff_sub_d);
    s1_inf_d     = (a_inf || b_inf) && !s1_nan_d;
    s1_sign_d    = s1_swapped_d ? b_sign_eff : opa[31];
    s1_exp_l_d   = s1_swapped_d ? b_exp  : a_exp;
    s1_exp_s_d   = s1_swapped_d ? a_exp  : b_exp;
    s1_mant_l_d  = s1_swapped_d ? b_mant : a_mant;
    s1_mant_s_d  = s1_swapped_d ? a_mant : b_mant;
  end

  logic [7:0]  diff;
  logic [4:0]  sh;
  logic [26:0] m_small, shifted, lost_mask;

  always_comb begin
    diff      = s1_exp_l_q - s1_exp_s_q;
    sh        = diff[4:0];
    m_small   = {s1_mant_s_q, 3'b000};
    shifted   = m_small >> sh;
    lost_mask = ~({27{1'b1}} << sh);
    // Beyond 26 positions everything lands in sticky.
    if (diff >= 8'd27) begin
      out_mant_b_d = {26'd0, |m_small};
    end else begin
      out_mant_b_d = {shifted[26:1], shifted[0] | (|(m_small & lost_mask))};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_exp_l_q   <= 8'd0;
      s1_exp_s_q   <= 8'd0;
      s1_mant_l_q  <= 24'd0;
      s1_mant_s_q  <= 24'd0;
      s1_sign_q    <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_swapped_q <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_inf_q     <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q   <= in_valid;
      s1_exp_l_q   <= s1_exp_l_d;
      s1_exp_s_q   <= s1_exp_s_d;
      s1_mant_l_q  <= s1_mant_l_d;
      s1_mant_s_q  <= s1_mant_s_d;
      s1_sign_q    <= s1_sign_d;
      s1_eff_sub_q <= s1_eff_sub_d;
      s1_swapped_q <= s1_swapped_d;
      s1_nan_q     <= s1_nan_d;
      s1_inf_q     <= s1_inf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q    <= 1'b0;
      out_exp_q     <= 8'd0;
      out_mant_a_q  <= 27'd0;
      out_mant_b_q  <= 27'd0;
      out_sign_q    <= 1'b0;
      out_eff_sub_q <= 1'b0;
      out_swapped_q <= 1'b0;
      out_nan_q     <= 1'b0;
      out_inf_q     <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q    <= s1_valid_q;
      out_exp_q     <= s1_exp_l_q;
      out_mant_a_q  <= {s1_mant_l_q, 3'b000};
      out_mant_b_q  <= out_mant_b_d;
      out_sign_q    <= s1_sign_q;
      out_eff_sub_q <= s1_eff_sub_q;
      out_swapped_q <= s1_swapped_q;
      out_nan_q     <= s1_nan_q;
      out_inf_q     <= s1_inf_q;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_exp     = out_exp_q;
  assign out_mant_a  = out_mant_a_q;
  assign out_mant_b  = out_mant_b_q;
  assign out_sign    = out_sign_q;
  assign out_eff_sub = out_eff_sub_q;
  assign out_swapped = out_swapped_q;
  assign out_nan     = out_nan_q;
  assign out_inf     = out_inf_q;

endmodule

// File: tb/tb_fpu_add_align.sv
// Directed-vector bench for fpu_add_align: alignment results, backpressure and reset flush.
module tb_fpu_add_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        add_sub = 1'b1;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_exp;
  logic [26:0] out_mant_a, out_mant_b;
  logic        out_sign, out_eff_sub, out_swapped, out_nan, out_inf;

  int total = 0;
  int bad = 0;

  fpu_add_align dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .add_sub(add_sub), .opa(opa), .opb(opb), .out_valid(out_valid),
    .out_ready(out_ready), .out_exp(out_exp), .out_mant_a(out_mant_a),
    .out_mant_b(out_mant_b), .out_sign(out_sign), .out_eff_sub(out_eff_sub),
    .out_swapped(out_swapped), .out_nan(out_nan), .out_inf(out_inf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Expected fields packed as {sign, eff_sub, swapped, nan, inf}.
  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic as, input logic [7:0] e_exp, input logic [26:0] e_ma,
                         input logic [26:0] e_mb, input logic [4:0] e_flags);
    opa = a; opb = b; add_sub = as; in_valid = 1'b1;
    chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, ".early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, ".exp"}, {24'd0, out_exp}, {24'd0, e_exp});
    chk({name, ".ma"}, {5'd0, out_mant_a}, {5'd0, e_ma});
    chk({name, ".mb"}, {5'd0, out_mant_b}, {5'd0, e_mb});
    chk({name, ".flags"}, {27'd0, out_sign, out_eff_sub, out_swapped, out_nan, out_inf},
        {27'd0, e_flags});
    $display("vec %s: opa=%h opb=%h add_sub=%0d exp=%h ma=%h mb=%h", name, a, b, as,
             out_exp, out_mant_a, out_mant_b);
  endtask

  initial begin
    int sent, got;
    logic acc;

    #12;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.exp", {24'd0, out_exp}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b1, 8'h7F, 27'h4000000, 27'h4000000, 5'b00000);
    run_vec("shift24", 32'h3F800000, 32'h4B800000, 1'b1, 8'h97, 27'h4000000, 27'h0000004, 5'b00100);
    run_vec("shift28_sub", 32'h3F800000, 32'h4D800000, 1'b0, 8'h9B, 27'h4000000, 27'h0000001, 5'b11100);
    run_vec("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b0, 8'hFF, 27'h4000000, 27'h4000000, 5'b01010);
    run_vec("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b1, 8'hFF, 27'h4000000, 27'h0000001, 5'b00001);
    run_vec("qnan", 32'h7FC00000, 32'h3F800000, 1'b1, 8'hFF, 27'h6000000, 27'h0000001, 5'b00010);
    run_vec("tie_cancel", 32'h3F800000, 32'hBF800000, 1'b1, 8'h7F, 27'h4000000, 27'h4000000, 5'b01000);
    run_vec("denormal", 32'h00000001, 32'h00000000, 1'b1, 8'h01, 27'h0000008, 27'h0000000, 5'b00000);
    run_vec("sticky4", 32'h3F800001, 32'h41800000, 1'b1, 8'h83, 27'h4000000, 27'h0400001, 5'b00100);
    run_vec("zero_far", 32'h00000000, 32'h4D800000, 1'b1, 8'h9B, 27'h4000000, 27'h0000000, 5'b00100);
    @(posedge clk); #1;

    // Backpressure: four pairs offered while the output stalls for six cycles.
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (sent < 4);
      add_sub   = 1'b1;
      opa = {1'b0, 8'd128 + 8'(sent), 23'd0};
      opb = 32'h3F800000;
      #3;
      if (cyc < 6) chk($sformatf("bp.in_ready%0d", cyc), {31'd0, in_ready}, (cyc < 2) ? 32'd1 : 32'd0);
      if (cyc >= 2 && cyc < 6) begin
        chk($sformatf("bp.hold_valid%0d", cyc), {31'd0, out_valid}, 32'd1);
        chk($sformatf("bp.hold_exp%0d", cyc), {24'd0, out_exp}, 32'h80);
        chk($sformatf("bp.hold_mb%0d", cyc), {5'd0, out_mant_b}, 32'h2000000);
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("bp.exp%0d", got), {24'd0, out_exp}, 32'd128 + 32'(got));
        chk($sformatf("bp.mb%0d", got), {5'd0, out_mant_b}, 32'h4000000 >> (got + 1));
        $display("bp out %0d: exp=%h mb=%h", got, out_exp, out_mant_b);
        got++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      if (cyc == 5) chk("bp.accepted", 32'(sent), 32'd2);
    end
    in_valid = 1'b0;
    chk("bp.count", 32'(got), 32'd4);
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("bp.nodup%0d", k), {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset with two pairs in flight.
    out_ready = 1'b1;
    in_valid = 1'b1; opa = 32'h40000000; opb = 32'h3F800000;
    @(posedge clk); #1;
    opa = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst2.inflight", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2.drop", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst2.in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst2.quiet%0d", k), {31'd0, out_valid}, 32'd0);
    end
    $display("reset flush done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
